instr_encoder_loader: RTL

//  Encoder side of the main opcode decoder: turns a symbolic instruction request into a 32-bit MIPS word.

---
 rtl/instr_encoder_loader_pkg.sv | 44 ++++
 rtl/instr_field_encoder.sv | 32 +++
 rtl/instr_encoder_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared MIPS opcode/funct constants, op select codes and loader FSM states
// used by the instruction encoder/loader and its companion disassembler bench.
package instr_encoder_loader_pkg;

    typedef enum logic [2:0] {
        OP_ADDU    = 3'd0,
        OP_SUBU    = 3'd1,
        OP_ORI     = 3'd2,
        OP_LW      = 3'd3,
        OP_SW      = 3'd4,
        OP_BEQ     = 3'd5,
        OP_JAL     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [5:0] ADDU_OPCODE = 6'b000000;
    localparam logic [5:0] SUBU_OPCODE = 6'b000000;
    localparam logic [5:0] ORI_OPCODE  = 6'b001101;
    localparam logic [5:0] LW_OPCODE   = 6'b100011;
    localparam logic [5:0] SW_OPCODE   = 6'b101011;
    localparam logic [5:0] BEQ_OPCODE  = 6'b000100;
    localparam logic [5:0] JAL_OPCODE  = 6'b000011;

    localparam logic [5:0] ADDU_FUNCT  = 6'b100001;
    localparam logic [5:0] SUBU_FUNCT  = 6'b100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [31:0] r_type(input logic [5:0] opcode, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [5:0] funct);
        return {opcode, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opcode, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opcode, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Purely combinational encoder: op select plus register/immediate/target fields
// to a 32-bit MIPS instruction word, flagging the illegal select.
module instr_field_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel)
            OP_ADDU: word = r_type(ADDU_OPCODE, rs, rt, rd, ADDU_FUNCT);
            OP_SUBU: word = r_type(SUBU_OPCODE, rs, rt, rd, SUBU_FUNCT);
            OP_ORI:  word = i_type(ORI_OPCODE, rs, rt, imm);
            OP_LW:   word = i_type(LW_OPCODE, rs, rt, imm);
            OP_SW:   word = i_type(SW_OPCODE, rs, rt, imm);
            OP_BEQ:  word = i_type(BEQ_OPCODE, rs, rt, imm);
            OP_JAL:  word = {JAL_OPCODE, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes accepted instruction requests and streams them as
// one-cycle write strobes into instruction memory at consecutive word addresses.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              load_done,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                load_done_q, load_done_d;
    logic                err_illegal_q, err_illegal_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;

    logic [31:0]         enc_word;
    logic                enc_illegal;
    logic                accept;

    instr_field_encoder u_encoder (
        .op_sel  (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .imm     (imm),
        .target  (target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign req_ready = (state_q == ST_LOAD) && !start && !finish;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        count_d       = count_q;
        load_done_d   = load_done_q;
        err_illegal_d = err_illegal_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;

        // The write strobe is registered at the accept edge, so an in-flight write
        // is already on the bus when start/finish arrive and is never cancelled.
        if (start) begin
            state_d       = ST_LOAD;
            addr_d        = '0;
            count_d       = '0;
            load_done_d   = 1'b0;
            err_illegal_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (finish) begin
                state_d     = ST_DONE;
                load_done_d = 1'b1;
            end else if (accept) begin
                if (enc_illegal) begin
                    err_illegal_d = 1'b1;
                end else begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_q;
                    imem_wdata_d = enc_word;
                    addr_d       = addr_q + 1'b1;
                    count_d      = count_q + 1'b1;
                    if (count_d == DEPTH_C) begin
                        state_d     = ST_DONE;
                        load_done_d = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            load_done_q   <= 1'b0;
            err_illegal_q <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            load_done_q   <= load_done_d;
            err_illegal_q <= err_illegal_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
        end
    end

    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign count       = count_q;
    assign load_done   = load_done_q;
    assign err_illegal = err_illegal_q;

endmodule
